// File: rtl/traffic_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and constants for the intersection controller:
//               lamp colour encoding, controller state encoding and the
//               timer length width.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Width of the countdown timer length field
  localparam int TLEN_W = 5;

  // Lamp colour as driven onto the lamp outputs
  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  // Controller state; encoding 3'd7 is unused and recovers to ALL_RED_B
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    PED_WALK    = 3'd6
  } state_t;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/traffic_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_ctrl_if
// Description : Handshake between the intersection controller and the shared
//               countdown timer.
//   t_start   : one-cycle timer start (controller -> timer)
//   t_length  : timer duration for the current phase (controller -> timer)
//   t_done    : timer expired, level (timer -> controller)
//   t_flicker : timer within its last 5 ticks (timer -> controller)
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_ctrl_if;

  logic                           t_start;
  logic [traffic_pkg::TLEN_W-1:0] t_length;
  logic                           t_done;
  logic                           t_flicker;

  // Controller side
  modport master (
    output t_start,
    output t_length,
    input  t_done,
    input  t_flicker
  );

  // Timer side
  modport slave (
    input  t_start,
    input  t_length,
    output t_done,
    output t_flicker
  );

endinterface : traffic_ctrl_if
`default_nettype wire

// File: rtl/traffic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_ctrl
// Description : Moore controller for a main/side intersection with a
//               pedestrian crossing. Starts the external countdown timer on
//               entry to every phase and advances on timer expiry.
// Ports       :
//   clk        in   system clock, rising edge
//   reset      in   synchronous reset, active low
//   side_car   in   side-road vehicle sensor (level)
//   ped_req    in   pedestrian button (pulse of any width)
//   tmr        if   timer handshake (master modport)
//   main_light out  main-road lamp
//   side_light out  side-road lamp
//   walk       out  pedestrian walk lamp
//   walk_flash out  walk lamp flashing (last timer ticks of the walk phase)
//   state_dbg  out  current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN_LEN = 20,
  parameter int SIDE_GREEN_LEN = 10,
  parameter int YELLOW_LEN     = 4,
  parameter int ALL_RED_LEN    = 2,
  parameter int WALK_LEN       = 12
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            side_car,
  input  wire logic            ped_req,
  traffic_ctrl_if.master       tmr,
  output light_t               main_light,
  output light_t               side_light,
  output logic                 walk,
  output logic                 walk_flash,
  output logic [2:0]           state_dbg
);

  localparam logic [TLEN_W-1:0] C_MAIN_GREEN_LEN = TLEN_W'(MAIN_GREEN_LEN);
  localparam logic [TLEN_W-1:0] C_SIDE_GREEN_LEN = TLEN_W'(SIDE_GREEN_LEN);
  localparam logic [TLEN_W-1:0] C_YELLOW_LEN     = TLEN_W'(YELLOW_LEN);
  localparam logic [TLEN_W-1:0] C_ALL_RED_LEN    = TLEN_W'(ALL_RED_LEN);
  localparam logic [TLEN_W-1:0] C_WALK_LEN       = TLEN_W'(WALK_LEN);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_start_pending;
  logic               r_ped_pending;
  logic               w_done_q;
  logic               w_enter_walk;
  logic [TLEN_W-1:0]  w_length;
  light_t             w_main_light;
  light_t             w_side_light;

  // t_done still reflects the previous phase during the entry cycle, so it
  // only counts once the start pulse for this phase has gone out.
  assign w_done_q     = tmr.t_done & ~r_start_pending;
  assign w_enter_walk = (w_next_state == PED_WALK) && (r_state != PED_WALK);

  // --------------------------------------------------------------------------
  // State register, start pulse and pedestrian latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ALL_RED_B;
      r_start_pending <= 1'b1;
      r_ped_pending   <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      // Any state change (including recovery from an illegal code) restarts
      // the timer; holding in MAIN_GREEN does not.
      r_start_pending <= (w_next_state != r_state);
      // Clearing on walk entry takes priority over a coincident request.
      if (w_enter_walk) begin
        r_ped_pending <= 1'b0;
      end else if (ped_req && (r_state != PED_WALK)) begin
        r_ped_pending <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and Moore output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_length     = C_ALL_RED_LEN;
    w_main_light = RED;
    w_side_light = RED;

    case (r_state)
      MAIN_GREEN: begin
        w_length     = C_MAIN_GREEN_LEN;
        w_main_light = GREEN;
        // Minimum green elapsed: wait here (timer stays expired) until
        // somebody actually needs the intersection.
        if (w_done_q && (side_car || r_ped_pending)) begin
          w_next_state = MAIN_YELLOW;
        end
      end
      MAIN_YELLOW: begin
        w_length     = C_YELLOW_LEN;
        w_main_light = YELLOW;
        if (w_done_q) begin
          w_next_state = ALL_RED_A;
        end
      end
      ALL_RED_A: begin
        w_length = C_ALL_RED_LEN;
        if (w_done_q) begin
          w_next_state = r_ped_pending ? PED_WALK : SIDE_GREEN;
        end
      end
      SIDE_GREEN: begin
        w_length     = C_SIDE_GREEN_LEN;
        w_side_light = GREEN;
        if (w_done_q) begin
          w_next_state = SIDE_YELLOW;
        end
      end
      SIDE_YELLOW: begin
        w_length     = C_YELLOW_LEN;
        w_side_light = YELLOW;
        if (w_done_q) begin
          w_next_state = ALL_RED_B;
        end
      end
      ALL_RED_B: begin
        w_length = C_ALL_RED_LEN;
        if (w_done_q) begin
          w_next_state = MAIN_GREEN;
        end
      end
      PED_WALK: begin
        w_length = C_WALK_LEN;
        if (w_done_q) begin
          w_next_state = ALL_RED_B;
        end
      end
      default: begin
        w_next_state = ALL_RED_B;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The pending start flag is already set while reset is held; gate it so
  // the timer sees no start until reset is released.
  assign tmr.t_start  = r_start_pending & reset;
  assign tmr.t_length = w_length;
  assign main_light   = w_main_light;
  assign side_light   = w_side_light;
  assign walk         = (r_state == PED_WALK);
  assign walk_flash   = tmr.t_flicker & (r_state == PED_WALK);
  assign state_dbg    = r_state;

endmodule : traffic_ctrl
`default_nettype wire

// File: tb/tb_traffic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_ctrl
// Description : Self-checking bench for traffic_ctrl. Contains a behavioural
//               countdown timer and a table of expected phase records.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_ctrl;
  import traffic_pkg::*;

  logic   clk;
  logic   reset;
  logic   side_car;
  logic   ped_req;
  light_t main_light;
  light_t side_light;
  logic   walk;
  logic   walk_flash;
  logic [2:0] state_dbg;

  int total;
  int bad;
  bit mon_en;

  traffic_ctrl_if bus ();

  traffic_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .side_car   (side_car),
    .ped_req    (ped_req),
    .tmr        (bus),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .walk_flash (walk_flash),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural timer: loads on start, counts down to zero, done while zero,
  // flicker during the last five non-zero counts.
  logic [4:0] tm_cnt;
  always @(posedge clk) begin
    if (!reset)             tm_cnt <= 5'd0;
    else if (bus.t_start)   tm_cnt <= bus.t_length;
    else if (tm_cnt != 5'd0) tm_cnt <= tm_cnt - 5'd1;
  end
  assign bus.t_done    = (tm_cnt == 5'd0);
  assign bus.t_flicker = (tm_cnt != 5'd0) && (tm_cnt <= 5'd5);

  typedef struct {
    state_t     st;
    logic [4:0] len;
    light_t     ml;
    light_t     sl;
    logic       wk;
    int         flash;
  } phase_t;

  phase_t tbl [7];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Safety invariants checked every cycle while enabled
  always @(negedge clk) begin
    if (mon_en) begin
      #1;
      chk("lamp_excl", int'(main_light != RED && side_light != RED), 0);
      chk("walk_red", int'(walk && (main_light != RED || side_light != RED)), 0);
      chk("flash_wo_walk", int'(walk_flash && !walk), 0);
    end
  end

  // Wait for a phase entry (t_start) and check its entry-cycle outputs
  task automatic enter(input int r);
    int w;
    w = 0;
    #1;
    while (!bus.t_start && w < 100) begin
      @(negedge clk); #1;
      w++;
    end
    chk("enter_start", int'(bus.t_start), 1);
    chk("enter_state", int'(state_dbg), int'(tbl[r].st));
    chk("enter_len", int'(bus.t_length), int'(tbl[r].len));
    chk("enter_main", int'(main_light), int'(tbl[r].ml));
    chk("enter_side", int'(side_light), int'(tbl[r].sl));
    chk("enter_walk", int'(walk), int'(tbl[r].wk));
  endtask

  // Remain in the phase until the state changes; check its duration
  task automatic stay(input int r, input bit pulse_ped);
    int dur, wc, fc, starts;
    dur = 1; wc = int'(walk); fc = int'(walk_flash); starts = 0;
    while (dur < 200) begin
      @(negedge clk); #1;
      ped_req = 1'b0;
      if (int'(state_dbg) != int'(tbl[r].st)) break;
      dur++;
      wc += int'(walk);
      fc += int'(walk_flash);
      if (bus.t_start) starts++;
      if (int'(bus.t_length) != int'(tbl[r].len)) starts += 100;
      if (pulse_ped && dur == 3) ped_req = 1'b1;
    end
    ped_req = 1'b0;
    chk("phase_dur", dur, int'(tbl[r].len) + 2);
    chk("phase_stable", starts, 0);
    if (tbl[r].wk) begin
      chk("walk_cycles", wc, dur);
      chk("flash_cycles", fc, tbl[r].flash);
    end
  endtask

  // Stay in MAIN_GREEN without requests; no state change, no timer restart
  task automatic hold(input int n);
    int bad_st, st_cnt;
    bad_st = 0; st_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      if (int'(state_dbg) != int'(MAIN_GREEN)) bad_st++;
      if (bus.t_start) st_cnt++;
    end
    chk("hold_state", bad_st, 0);
    chk("hold_no_start", st_cnt, 0);
    chk("hold_main", int'(main_light), int'(GREEN));
  endtask

  int side_seq [5] = '{0, 1, 2, 3, 4};

  initial begin
    total = 0; bad = 0; mon_en = 1'b0;
    reset = 1'b0; side_car = 1'b0; ped_req = 1'b0;

    tbl[0] = '{MAIN_YELLOW, 5'd4,  YELLOW, RED,    1'b0, 0};
    tbl[1] = '{ALL_RED_A,   5'd2,  RED,    RED,    1'b0, 0};
    tbl[2] = '{SIDE_GREEN,  5'd10, RED,    GREEN,  1'b0, 0};
    tbl[3] = '{SIDE_YELLOW, 5'd4,  RED,    YELLOW, 1'b0, 0};
    tbl[4] = '{ALL_RED_B,   5'd2,  RED,    RED,    1'b0, 0};
    tbl[5] = '{MAIN_GREEN,  5'd20, GREEN,  RED,    1'b0, 0};
    tbl[6] = '{PED_WALK,    5'd12, RED,    RED,    1'b1, 5};

    // Reset held low for two cycles
    @(negedge clk); #1;
    chk("rst_state", int'(state_dbg), int'(ALL_RED_B));
    chk("rst_start", int'(bus.t_start), 0);
    chk("rst_main", int'(main_light), int'(RED));
    chk("rst_side", int'(side_light), int'(RED));
    chk("rst_walk", int'(walk), 0);
    chk("rst_flash", int'(walk_flash), 0);
    @(negedge clk);
    mon_en = 1'b1;
    reset  = 1'b1;

    // First clearance phase, then MAIN_GREEN with no demand
    enter(4); stay(4, 1'b0);
    enter(5);
    hold(100);

    // Side car arrives: leaves on the very next cycle
    side_car = 1'b1;
    @(negedge clk); #1;
    chk("mg_exit_now", int'(state_dbg), int'(MAIN_YELLOW));
    for (int i = 0; i < 5; i++) begin
      enter(side_seq[i]); stay(side_seq[i], 1'b0);
    end

    // Back in MAIN_GREEN: pedestrian plus side car; pedestrian wins
    enter(5);
    @(negedge clk); #1;
    ped_req = 1'b1;
    @(negedge clk); #1;
    ped_req = 1'b0;
    tbl[5].len = 5'd20;
    begin
      int dur;
      dur = 3;
      while (int'(state_dbg) == int'(MAIN_GREEN) && dur < 100) begin
        @(negedge clk); #1;
        dur++;
      end
      chk("mg_demand_dur", dur - 1, 22);
    end
    enter(0); stay(0, 1'b0);
    enter(1); stay(1, 1'b0);
    enter(6);
    side_car = 1'b0;
    stay(6, 1'b1);   // ped_req pulsed mid-walk must not latch
    enter(4); stay(4, 1'b0);
    enter(5);
    hold(40);

    // Side car again: served by SIDE_GREEN, not another walk
    side_car = 1'b1;
    enter(0); stay(0, 1'b0);
    enter(1); stay(1, 1'b0);
    enter(2);

    // Latch a pedestrian request, then reset mid SIDE_GREEN
    @(negedge clk); #1;
    ped_req = 1'b1;
    @(negedge clk); #1;
    ped_req  = 1'b0;
    side_car = 1'b0;
    reset    = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_state", int'(state_dbg), int'(ALL_RED_B));
    chk("mid_rst_main", int'(main_light), int'(RED));
    chk("mid_rst_side", int'(side_light), int'(RED));
    chk("mid_rst_walk", int'(walk), 0);
    chk("mid_rst_start", int'(bus.t_start), 0);
    reset = 1'b1;
    #1;
    chk("mid_rel_start", int'(bus.t_start), 1);
    enter(4); stay(4, 1'b0);
    enter(5);
    hold(40);       // cleared pedestrian request keeps MAIN_GREEN held

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_traffic_ctrl
`default_nettype wire
